front_panel_sequencer: RTL
==========================

Name: front_panel_sequencer

Overview:
Consumes switch positions produced by the front panel renderer and turns them into Altair 8800 console operations: run/stop, single step, examine, deposit, reset, protect. Drives the memory port and CPU control strobes, and produces the 36 LED states the renderer draws. Sits between the front panel graphics block and the CPU/memory subsystem; it is the only console-side master of memory while the CPU is stopped.

Parameters:
MEM_TIMEOUT, 255, cycles to wait for mem_ack before aborting an access
RESET_PULSE_CYCLES, 16, width of the cpu_reset pulse
PROT_PAGE_BITS, 6, address MSBs forming a protect page (64 pages of 1 KB)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
switches_status[0:24]  in  2 each  00 centre/off, 01 up, 10 down, 11 illegal (treated as 00)
leds_status[0:35]  out  1 each  LED states to renderer
mem_addr  out  16  console memory address
mem_wdata  out  8  deposit data
mem_rdata  in  8  examine data
mem_req  out  1  access request, held until ack
mem_we  out  1  1 = write, valid with mem_req
mem_ack  in  1  single-cycle completion
cpu_run  out  1  level, CPU may execute
cpu_step  out  1  one-cycle pulse, execute one instruction
cpu_step_done  in  1  single-cycle pulse, step finished
cpu_reset  out  1  reset pulse to CPU
cpu_addr  in  16  CPU address bus
cpu_data  in  8  CPU data bus
cpu_status  in  10  INTE PROT MEMR INP M1 OUT HLTA STACK WO INT
cpu_wait  in  1  CPU waiting
cpu_hlda  in  1  hold acknowledge

Behaviour:
- Switch map: 0..15 SA0..SA15 (toggle, 01 = 1); 16 STOP(01)/RUN(10); 17 SINGLE STEP(01); 18 EXAMINE(01)/EXAMINE NEXT(10); 19 DEPOSIT(01)/DEPOSIT NEXT(10); 20 RESET(01)/CLR(10); 21 PROTECT(01)/UNPROTECT(10); 22-23 AUX, ignored; 24 POWER (01 = on).
- Commands fire on the transition of a control switch from 00 to 01/10 (registered previous value); holding a switch never re-fires.
- Simultaneous edges, one command accepted per cycle, priority RESET/CLR > STOP > RUN > STEP > EXAMINE* > DEPOSIT* > PROTECT*; losers dropped.
- Reset values: all outputs 0, panel_addr=0, panel_data=0, protect bitmap all 0, state OFF.
- States: OFF, STOPPED, RUNNING, MEM_RD, MEM_WR, STEP_WAIT, RST_PULSE.
- OFF: entered whenever switch 24 != 01 (overrides any state, aborts mem_req same cycle); all LEDs 0. On 00->01 of switch 24 -> RST_PULSE.
- RST_PULSE: cpu_reset=1 for RESET_PULSE_CYCLES, cpu_run=0, then STOPPED. CLR clears protect bitmap, does not pulse reset.
- STOPPED: RUN -> RUNNING (cpu_run=1 next cycle). STEP -> pulse cpu_step 1 cycle, STEP_WAIT until cpu_step_done, then STOPPED, panel_addr=cpu_addr.
- EXAMINE: panel_addr=SA[15:0]; EXAMINE NEXT: panel_addr+1 mod 2^16 (FFFF wraps to 0000); both -> MEM_RD.
- DEPOSIT: write SA[7:0] at panel_addr; DEPOSIT NEXT: panel_addr+1 first (wraps), then write; both -> MEM_WR unless page protected, then stay STOPPED, no access.
- MEM_RD/MEM_WR: mem_req=1 with stable addr/we/wdata until mem_ack; on ack panel_data=mem_rdata (read) or wdata (write), -> STOPPED. No ack in MEM_TIMEOUT cycles: drop req, panel_data=FF, -> STOPPED.
- RUNNING: only STOP, RESET/CLR, POWER honoured; STOP -> cpu_run=0, STOPPED, panel_addr=cpu_addr. All other commands dropped.
- PROTECT/UNPROTECT (STOPPED only): set/clear bit panel_addr[15:16-PROT_PAGE_BITS].
- LEDs (registered, 1-cycle latency): 0..15 A0..A15, 16..23 D0..D7 from cpu_addr/cpu_data in RUNNING else panel_addr/panel_data; 24..33 cpu_status, except 25 PROT = protect bit of displayed address; 34 WAIT = cpu_wait or not RUNNING; 35 HLDA.
- Async reset mid-access drops mem_req immediately.

Decomposition:
- front_panel_pkg: switch index constants, LED index constants, switch code values (SW_OFF, SW_UP, SW_DOWN), state enum, command enum.
- Sub-module panel_cmd_decode: edge detect plus priority encode of switches 16..24 into one command per cycle.

Test Plan:
- Power 00->01 -> cpu_reset high 16 cycles, then STOPPED, LEDs 0..23 all 0, LED34=1.
- SA=0x1234, EXAMINE, mem_rdata=0xAB ack after 3 cycles -> mem_addr=0x1234, we=0; LEDs A=0x1234, D=0xAB.
- panel_addr=0xFFFF, SA[7:0]=0x5A, DEPOSIT NEXT -> write 0x5A at 0x0000, LED D=0x5A.
- PROTECT at 0x0400, then DEPOSIT at 0x0400 -> no mem_req, LED25=1; UNPROTECT then DEPOSIT -> write issued.
- RUN, then EXAMINE and STOP edges in same cycle -> STOP wins, cpu_run=0, EXAMINE dropped.
- EXAMINE with mem_ack never asserted -> mem_req drops after 255 cycles, LED D=0xFF; power off mid-MEM_RD -> mem_req 0 next cycle.

Source files
------------

// File: rtl/front_panel_pkg.sv
// Shared constants and types for the Altair front panel sequencer.
package front_panel_pkg;

    localparam int NUM_SWITCHES = 25;
    localparam int NUM_LEDS     = 36;

    // Switch positions on the panel
    localparam int SW_SA_LSB   = 0;
    localparam int SW_RUN_STOP = 16;
    localparam int SW_STEP     = 17;
    localparam int SW_EXAMINE  = 18;
    localparam int SW_DEPOSIT  = 19;
    localparam int SW_RESET    = 20;
    localparam int SW_PROTECT  = 21;
    localparam int SW_AUX0     = 22;
    localparam int SW_AUX1     = 23;
    localparam int SW_POWER    = 24;

    // LED positions on the panel
    localparam int LED_ADDR_LSB   = 0;
    localparam int LED_DATA_LSB   = 16;
    localparam int LED_STATUS_LSB = 24;
    localparam int LED_PROT       = 25;
    localparam int LED_WAIT       = 34;
    localparam int LED_HLDA       = 35;

    // Switch lever codes
    localparam logic [1:0] SW_OFF  = 2'b00;
    localparam logic [1:0] SW_UP   = 2'b01;
    localparam logic [1:0] SW_DOWN = 2'b10;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_STOPPED,
        ST_RUNNING,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_STEP_WAIT,
        ST_RST_PULSE
    } state_t;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_RESET,
        CMD_CLR,
        CMD_STOP,
        CMD_RUN,
        CMD_STEP,
        CMD_EXAMINE,
        CMD_EXAMINE_NEXT,
        CMD_DEPOSIT,
        CMD_DEPOSIT_NEXT,
        CMD_PROTECT,
        CMD_UNPROTECT
    } cmd_t;

    // The illegal 11 code reads as a centred lever
    function automatic logic [1:0] sw_norm(input logic [1:0] code);
        return (code == 2'b11) ? SW_OFF : code;
    endfunction

endpackage

// File: rtl/front_panel_sequencer_if.sv
// Memory port and CPU control/status bundle seen by the console sequencer.
interface front_panel_sequencer_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        cpu_run;
    logic        cpu_step;
    logic        cpu_step_done;
    logic        cpu_reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic [9:0]  cpu_status;
    logic        cpu_wait;
    logic        cpu_hlda;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        output cpu_run, cpu_step, cpu_reset,
        input  mem_rdata, mem_ack, cpu_step_done,
        input  cpu_addr, cpu_data, cpu_status, cpu_wait, cpu_hlda
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        input  cpu_run, cpu_step, cpu_reset,
        output mem_rdata, mem_ack, cpu_step_done,
        output cpu_addr, cpu_data, cpu_status, cpu_wait, cpu_hlda
    );
endinterface

// File: rtl/front_panel_sequencer_cmd_decode.sv
// Edge detection on the control levers and priority selection of one command.
module panel_cmd_decode
    import front_panel_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ctrl_sw [0:8],
    output cmd_t       cmd,
    output logic       power_on,
    output logic       power_edge
);
    localparam int I_RUN  = SW_RUN_STOP - SW_RUN_STOP;
    localparam int I_STEP = SW_STEP     - SW_RUN_STOP;
    localparam int I_EXAM = SW_EXAMINE  - SW_RUN_STOP;
    localparam int I_DEP  = SW_DEPOSIT  - SW_RUN_STOP;
    localparam int I_RST  = SW_RESET    - SW_RUN_STOP;
    localparam int I_PROT = SW_PROTECT  - SW_RUN_STOP;
    localparam int I_AUX0 = SW_AUX0     - SW_RUN_STOP;
    localparam int I_AUX1 = SW_AUX1     - SW_RUN_STOP;
    localparam int I_PWR  = SW_POWER    - SW_RUN_STOP;

    logic [1:0] cur_sw  [0:8];
    logic [1:0] prev_sw [0:8];
    logic [8:0] fired;
    logic       unused_aux;

    // Normalise lever codes and flag a lever that just left the centre position
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            cur_sw[i] = sw_norm(ctrl_sw[i]);
            fired[i]  = (prev_sw[i] == SW_OFF) && (cur_sw[i] != SW_OFF);
        end
    end

    assign unused_aux = ^{prev_sw[I_AUX0], prev_sw[I_AUX1], cur_sw[I_AUX0], cur_sw[I_AUX1],
                          fired[I_AUX0], fired[I_AUX1]};

    // Remember last lever positions so a held lever fires only once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) prev_sw[i] <= SW_OFF;
        end else begin
            for (int i = 0; i < 9; i++) prev_sw[i] <= cur_sw[i];
        end
    end

    assign power_on   = (cur_sw[I_PWR] == SW_UP);
    assign power_edge = fired[I_PWR] && power_on;

    // Pick the single highest-priority new command; all others this cycle are lost
    always_comb begin
        cmd = CMD_NONE;
        if (fired[I_RST])
            cmd = (cur_sw[I_RST] == SW_UP) ? CMD_RESET : CMD_CLR;
        else if (fired[I_RUN] && cur_sw[I_RUN] == SW_UP)
            cmd = CMD_STOP;
        else if (fired[I_RUN])
            cmd = CMD_RUN;
        else if (fired[I_STEP] && cur_sw[I_STEP] == SW_UP)
            cmd = CMD_STEP;
        else if (fired[I_EXAM])
            cmd = (cur_sw[I_EXAM] == SW_UP) ? CMD_EXAMINE : CMD_EXAMINE_NEXT;
        else if (fired[I_DEP])
            cmd = (cur_sw[I_DEP] == SW_UP) ? CMD_DEPOSIT : CMD_DEPOSIT_NEXT;
        else if (fired[I_PROT])
            cmd = (cur_sw[I_PROT] == SW_UP) ? CMD_PROTECT : CMD_UNPROTECT;
    end

endmodule

// File: rtl/front_panel_sequencer.sv
// Console sequencer: turns panel lever commands into CPU control and memory accesses.
module front_panel_sequencer
    import front_panel_pkg::*;
#(
    parameter int MEM_TIMEOUT        = 255,
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int PROT_PAGE_BITS     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] switches_status [0:24],
    output logic       leds_status [0:35],
    front_panel_sequencer_if.master bus
);
    localparam int NUM_PAGES = 1 << PROT_PAGE_BITS;
    localparam int TIMER_W   = $clog2(MEM_TIMEOUT + 1);
    localparam int PULSE_W   = $clog2(RESET_PULSE_CYCLES + 1);

    state_t                 state, state_n;
    cmd_t                   cmd;
    logic                   power_on, power_edge;
    logic [1:0]             ctrl_sw [0:8];
    logic [15:0]            sa;
    logic [15:0]            panel_addr, panel_addr_n, addr_inc;
    logic [7:0]             panel_data, panel_data_n;
    logic [7:0]             wdata_q, wdata_n;
    logic [NUM_PAGES-1:0]   protect_bits, protect_n;
    logic                   step_q, step_n;
    logic [TIMER_W-1:0]     timer;
    logic [PULSE_W-1:0]     pulse_cnt;
    logic [15:0]            disp_addr;
    logic [7:0]             disp_data;
    logic [35:0]            leds_q, leds_n;
    logic                   unused_status;

    function automatic logic [PROT_PAGE_BITS-1:0] page_of(input logic [15:0] a);
        return a[15 -: PROT_PAGE_BITS];
    endfunction

    // Address/data levers as a plain word, control levers handed to the decoder
    always_comb begin
        for (int i = 0; i < 16; i++) sa[i] = (sw_norm(switches_status[SW_SA_LSB + i]) == SW_UP);
        for (int i = 0; i < 9; i++) ctrl_sw[i] = switches_status[SW_RUN_STOP + i];
    end

    panel_cmd_decode u_decode (
        .clk        (clk),
        .reset      (reset),
        .ctrl_sw    (ctrl_sw),
        .cmd        (cmd),
        .power_on   (power_on),
        .power_edge (power_edge)
    );

    assign addr_inc = panel_addr + 16'd1;

    // Next-state logic; losing power overrides everything and forces OFF
    always_comb begin
        state_n      = state;
        panel_addr_n = panel_addr;
        panel_data_n = panel_data;
        wdata_n      = wdata_q;
        protect_n    = protect_bits;
        step_n       = 1'b0;
        if (!power_on) begin
            state_n = ST_OFF;
        end else begin
            case (state)
                ST_OFF: if (power_edge) state_n = ST_RST_PULSE;
                ST_RST_PULSE: if (pulse_cnt == PULSE_W'(RESET_PULSE_CYCLES - 1)) state_n = ST_STOPPED;
                ST_STOPPED: begin
                    case (cmd)
                        CMD_RESET: state_n = ST_RST_PULSE;
                        CMD_CLR:   protect_n = '0;
                        CMD_RUN:   state_n = ST_RUNNING;
                        CMD_STEP: begin
                            step_n  = 1'b1;
                            state_n = ST_STEP_WAIT;
                        end
                        CMD_EXAMINE: begin
                            panel_addr_n = sa;
                            state_n      = ST_MEM_RD;
                        end
                        CMD_EXAMINE_NEXT: begin
                            panel_addr_n = addr_inc;
                            state_n      = ST_MEM_RD;
                        end
                        CMD_DEPOSIT: begin
                            wdata_n = sa[7:0];
                            if (!protect_bits[page_of(panel_addr)]) state_n = ST_MEM_WR;
                        end
                        CMD_DEPOSIT_NEXT: begin
                            panel_addr_n = addr_inc;
                            wdata_n      = sa[7:0];
                            if (!protect_bits[page_of(addr_inc)]) state_n = ST_MEM_WR;
                        end
                        CMD_PROTECT:   protect_n[page_of(panel_addr)] = 1'b1;
                        CMD_UNPROTECT: protect_n[page_of(panel_addr)] = 1'b0;
                        default: ;
                    endcase
                end
                ST_RUNNING: begin
                    case (cmd)
                        CMD_RESET: state_n = ST_RST_PULSE;
                        CMD_CLR:   protect_n = '0;
                        CMD_STOP: begin
                            state_n      = ST_STOPPED;
                            panel_addr_n = bus.cpu_addr;
                        end
                        default: ;
                    endcase
                end
                ST_MEM_RD, ST_MEM_WR: begin
                    if (bus.mem_ack) begin
                        panel_data_n = (state == ST_MEM_RD) ? bus.mem_rdata : wdata_q;
                        state_n      = ST_STOPPED;
                    end else if (timer == TIMER_W'(MEM_TIMEOUT - 1)) begin
                        panel_data_n = 8'hFF;
                        state_n      = ST_STOPPED;
                    end
                end
                ST_STEP_WAIT: begin
                    if (bus.cpu_step_done) begin
                        state_n      = ST_STOPPED;
                        panel_addr_n = bus.cpu_addr;
                    end
                end
                default: state_n = ST_OFF;
            endcase
        end
    end

    // State and console registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_OFF;
            panel_addr   <= '0;
            panel_data   <= '0;
            wdata_q      <= '0;
            protect_bits <= '0;
            step_q       <= 1'b0;
        end else begin
            state        <= state_n;
            panel_addr   <= panel_addr_n;
            panel_data   <= panel_data_n;
            wdata_q      <= wdata_n;
            protect_bits <= protect_n;
            step_q       <= step_n;
        end
    end

    // Cycle counters for the memory timeout and the CPU reset pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            pulse_cnt <= '0;
        end else begin
            timer     <= (state == ST_MEM_RD || state == ST_MEM_WR) ? timer + 1'b1 : '0;
            pulse_cnt <= (state == ST_RST_PULSE) ? pulse_cnt + 1'b1 : '0;
        end
    end

    // The request drops combinationally on power loss so an access never outlives the panel
    assign bus.mem_req   = power_on && (state == ST_MEM_RD || state == ST_MEM_WR);
    assign bus.mem_we    = (state == ST_MEM_WR);
    assign bus.mem_addr  = panel_addr;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_run   = (state == ST_RUNNING);
    assign bus.cpu_step  = step_q;
    assign bus.cpu_reset = (state == ST_RST_PULSE);

    // The CPU status PROT bit is replaced by the console's own protect map
    assign unused_status = bus.cpu_status[8];

    // Build the LED image: live bus while running, console registers otherwise
    always_comb begin
        disp_addr = (state == ST_RUNNING) ? bus.cpu_addr : panel_addr;
        disp_data = (state == ST_RUNNING) ? bus.cpu_data : panel_data;
        leds_n    = '0;
        if (power_on && state != ST_OFF) begin
            leds_n[LED_ADDR_LSB +: 16] = disp_addr;
            leds_n[LED_DATA_LSB +: 8]  = disp_data;
            for (int i = 0; i < 10; i++) leds_n[LED_STATUS_LSB + i] = bus.cpu_status[9 - i];
            leds_n[LED_PROT] = protect_bits[page_of(disp_addr)];
            leds_n[LED_WAIT] = bus.cpu_wait || (state != ST_RUNNING);
            leds_n[LED_HLDA] = bus.cpu_hlda;
        end
    end

    // LED register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) leds_q <= '0;
        else       leds_q <= leds_n;
    end

    // Present the LED register to the renderer
    always_comb begin
        for (int i = 0; i < 36; i++) leds_status[i] = leds_q[i];
    end

endmodule
